// File: rtl/fetch_sequencer.sv
// Fetch-stage program counter sequencer: arbitrates EXE/WB redirects, applies
// decode stalls and instruction-memory wait, and raises pipeline flush pulses.
module fetch_sequencer #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_PC     = '0,
  parameter int           FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirectExe,
  input  logic [N-1:0] pcExe,
  input  logic         redirectWb,
  input  logic [N-1:0] pcWb,
  input  logic         stallReq,
  input  logic         memReady,
  output logic [N-1:0] pcOut,
  output logic         fetchValid,
  output logic         flushDecode,
  output logic         flushExe,
  output logic [15:0]  redirectCnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_WAIT_MEM,
    S_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [15:0]     redir_cnt_q, redir_cnt_d;

  logic            redirect;
  logic [N-1:0]    target;
  logic [N-1:0]    pc_inc;

  assign redirect = redirectExe | redirectWb;
  assign target   = redirectExe ? pcExe : pcWb;
  assign pc_inc   = pc_q + N'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = 1'b0;
    flush_d     = 1'b0;
    flush_cnt_d = flush_cnt_q;
    redir_cnt_d = redir_cnt_q;

    if (redirect) begin
      // A redirect wins in every state; a single-cycle window needs no FLUSH state.
      pc_d        = target;
      flush_d     = 1'b1;
      flush_cnt_d = FW'(FLUSH_CYCLES - 1);
      redir_cnt_d = (redir_cnt_q == 16'hFFFF) ? redir_cnt_q : redir_cnt_q + 16'd1;
      state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (stallReq) begin
            state_d = S_STALL;
          end else if (!memReady) begin
            state_d = S_WAIT_MEM;
          end else begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
          end
        end
        S_STALL: begin
          if (!stallReq) state_d = S_RUN;
        end
        S_WAIT_MEM: begin
          if (stallReq) begin
            state_d = S_STALL;
          end else if (memReady) begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
            state_d = S_RUN;
          end
        end
        S_FLUSH: begin
          // Stalls are ignored here: the squashed slots cannot carry a hazard.
          if (memReady) begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
          end
          if (flush_cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            flush_d     = 1'b1;
            flush_cnt_d = flush_cnt_q - FW'(1);
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      flush_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      flush_cnt_q <= flush_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign pcOut       = pc_q;
  assign fetchValid  = valid_q;
  assign flushDecode = flush_q;
  assign flushExe    = flush_q;
  assign redirectCnt = redir_cnt_q;

endmodule
